fetch_align_buffer: RTL and testbench

- Instruction-fetch front end that sits between the I-cache and the pipeline's IF/ID stage.
- Reads aligned 32-bit words from the I-cache into a halfword queue and presents one complete, correctly aligned RV32IC instruction per cycle, 16-bit or 32-bit, together with its PC.
- Absorbs instructions that straddle word boundaries and redirect targets at PC[1]=1, so the pipeline no longer needs a compression buffer or a PREPARE bubble.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_align_buffer_hw_queue.sv | 93 +++++++++
 rtl/fetch_align_buffer.sv | 128 ++++++++++++
 tb/tb_fetch_align_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch/align front end.
package fetch_pkg;

    localparam int HW_W   = 16;
    localparam int WORD_W = 32;

    // FS_RESET blocks the first request after reset; FS_WAIT holds a stalled request.
    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_RUN   = 2'd1,
        FS_WAIT  = 2'd2
    } fetch_state_e;

    function automatic logic is_rvc(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_align_buffer_hw_queue.sv
// Circular halfword FIFO: up to two pushes and two pops per cycle, flush wins.
module hw_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_lo_i,
    input  logic                       push_hi_i,
    input  logic [WORD_W-1:0]          push_data_i,
    input  logic                       pop1_i,
    input  logic                       pop2_i,
    output logic [HW_W-1:0]            h0_o,
    output logic [HW_W-1:0]            h1_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [HW_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       n_push;
    logic [1:0]       n_pop;
    logic [PTR_W-1:0] tail_p1;
    logic [HW_W-1:0]  wr0_data;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = (PTR_W+1)'(p) + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH)) begin
            s = s - (PTR_W+1)'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    assign n_push   = {1'b0, push_lo_i} + {1'b0, push_hi_i};
    assign n_pop    = pop2_i ? 2'd2 : {1'b0, pop1_i};
    assign tail_p1  = ptr_add(tail_q, 2'd1);
    // With only the upper half pushed, it lands in the tail slot.
    assign wr0_data = push_lo_i ? push_data_i[15:0] : push_data_i[31:16];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = ptr_add(head_q, n_pop);
            tail_d  = ptr_add(tail_q, n_push);
            count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (push_lo_i || push_hi_i) begin
                mem_q[tail_q] <= wr0_data;
            end
            if (push_lo_i && push_hi_i) begin
                mem_q[tail_p1] <= push_data_i[31:16];
            end
        end
    end

    assign h0_o    = mem_q[head_q];
    assign h1_o    = mem_q[ptr_add(head_q, 2'd1)];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetch front end: word requests to the I-cache, halfword queue, RV32IC alignment.
// Handshake: an instruction transfers on a cycle where instr_valid && instr_ready.
module fetch_align_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH_HW = 6
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_compressed
);

    localparam int CNT_W = $clog2(DEPTH_HW + 1);

    fetch_state_e     state_q, state_d;
    logic [29:0]      fetch_addr_q, fetch_addr_d;
    logic             drop_low_q, drop_low_d;
    logic [31:0]      out_pc_q, out_pc_d;

    logic [CNT_W-1:0] q_count;
    logic [HW_W-1:0]  h0, h1;
    logic             need2;
    logic             has_room;
    logic             accept;
    logic             fire;
    logic             unused_pc_bit;

    assign unused_pc_bit = redirect_pc[0];

    assign has_room = q_count <= CNT_W'(DEPTH_HW - 2);

    // Request FSM; a stalled request stays up until the cache answers or fetch restarts.
    always_comb begin
        state_d    = state_q;
        ICACHE_ren = 1'b0;
        case (state_q)
            FS_RESET: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                ICACHE_ren = has_room && !redirect_valid;
                if (ICACHE_ren && ICACHE_stall) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                ICACHE_ren = !redirect_valid;
                if (redirect_valid || !ICACHE_stall) begin
                    state_d = FS_RUN;
                end
            end
            default: begin
                state_d = FS_RUN;
            end
        endcase
    end

    assign ICACHE_addr = fetch_addr_q;
    assign accept      = ICACHE_ren && !ICACHE_stall;

    assign need2            = !is_rvc(h0);
    assign instr_valid      = (need2 ? (q_count >= CNT_W'(2)) : (q_count != '0)) && !redirect_valid;
    assign instr            = need2 ? {h1, h0} : {16'b0, h0};
    assign instr_pc         = out_pc_q;
    assign instr_compressed = !need2;
    assign fire             = instr_valid && instr_ready;

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        drop_low_d   = drop_low_q;
        out_pc_d     = out_pc_q;
        if (redirect_valid) begin
            fetch_addr_d = redirect_pc[31:2];
            drop_low_d   = redirect_pc[1];
            out_pc_d     = {redirect_pc[31:1], 1'b0};
        end else begin
            if (accept) begin
                fetch_addr_d = fetch_addr_q + 30'd1;
                drop_low_d   = 1'b0;
            end
            if (fire) begin
                out_pc_d = out_pc_q + (need2 ? 32'd4 : 32'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FS_RESET;
            fetch_addr_q <= RESET_PC[31:2];
            drop_low_q   <= RESET_PC[1];
            out_pc_q     <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            drop_low_q   <= drop_low_d;
            out_pc_q     <= out_pc_d;
        end
    end

    hw_queue #(
        .DEPTH(DEPTH_HW)
    ) u_queue (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (redirect_valid),
        .push_lo_i   (accept && !drop_low_q),
        .push_hi_i   (accept),
        .push_data_i (bswap32(ICACHE_rdata)),
        .pop1_i      (fire && !need2),
        .pop2_i      (fire && need2),
        .h0_o        (h0),
        .h1_o        (h1),
        .count_o     (q_count)
    );

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer with a zero-latency I-cache memory model.
module tb_fetch_align_buffer;

    logic        clk;
    logic        rst;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic        ICACHE_stall;
    logic [31:0] ICACHE_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;

    int checks;
    int failures;

    logic [31:0] mem [256];

    fetch_align_buffer #(
        .RESET_PC(32'h0000_0000),
        .DEPTH_HW(6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ICACHE_ren       (ICACHE_ren),
        .ICACHE_addr      (ICACHE_addr),
        .ICACHE_stall     (ICACHE_stall),
        .ICACHE_rdata     (ICACHE_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The cache stores words byte-swapped.
    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign ICACHE_rdata = swap(mem[ICACHE_addr[7:0]]);

    // addi x1, x0, i+1 : the instruction stored in word i of the low region
    function automatic logic [31:0] addi_word(input int i);
        return 32'h0000_0093 | (32'(i + 1) << 20);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || ICACHE_ren !== 1'b0) begin
            failures++;
            $display("FAIL redirect_cycle_quiet: valid=%b ren=%b want 0/0", instr_valid, ICACHE_ren);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || ICACHE_ren !== 1'b0) begin
            failures++;
            $display("FAIL reset_quiet: valid=%b ren=%b want 0/0", instr_valid, ICACHE_ren);
        end
        checks++;
        if (instr_pc !== 32'h0 || ICACHE_addr !== 30'h0 || dut.q_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: pc=%h addr=%h count=%0d want 0/0/0", instr_pc, ICACHE_addr, dut.q_count);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) begin
                checks++;
                if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'(i)) begin
                    failures++;
                    $display("FAIL seq_addr[%0d]: ren=%b addr=%h want 1/%h", i, ICACHE_ren, ICACHE_addr, i);
                end
            end
            checks++;
            if (i == 0) begin
                if (instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL seq_first_latency: valid=%b want 0", instr_valid);
                end
            end else if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (i - 1)) ||
                         instr !== addi_word(i - 1) || instr_compressed !== 1'b0) begin
                failures++;
                $display("FAIL seq_instr[%0d]: v=%b pc=%h instr=%h c=%b want 1/%h/%h/0",
                         i, instr_valid, instr_pc, instr, instr_compressed, 4 * (i - 1), addi_word(i - 1));
            end
        end
    endtask

    task automatic test_mixed();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        logic        exp_c  [3];
        int k;
        exp_pc = '{32'h40, 32'h42, 32'h46};
        exp_in = '{32'h0000_4085, 32'h0000_A103, 32'h0000_0085};
        exp_c  = '{1'b1, 1'b0, 1'b1};
        k = 0;
        do_redirect(32'h40);
        for (int c = 0; c < 10 && k < 3; c++) begin
            if (instr_valid === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc[k] || instr !== exp_in[k] || instr_compressed !== exp_c[k]) begin
                    failures++;
                    $display("FAIL mixed[%0d]: pc=%h instr=%h c=%b want %h/%h/%b",
                             k, instr_pc, instr, instr_compressed, exp_pc[k], exp_in[k], exp_c[k]);
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL mixed_timeout: got %0d instrs want 3", k);
        end
    endtask

    task automatic test_redirect_odd();
        do_redirect(32'h106);
        checks++;
        if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h41 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL odd_req1: ren=%b addr=%h v=%b want 1/41/0", ICACHE_ren, ICACHE_addr, instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || dut.q_count !== 3'd1 || ICACHE_addr !== 30'h42) begin
            failures++;
            $display("FAIL odd_half: v=%b count=%0d addr=%h want 0/1/42", instr_valid, dut.q_count, ICACHE_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h106 || instr !== 32'h0050_0293 || instr_compressed !== 1'b0) begin
            failures++;
            $display("FAIL odd_instr: v=%b pc=%h instr=%h c=%b want 1/106/00500293/0",
                     instr_valid, instr_pc, instr, instr_compressed);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h10A || instr !== 32'h0000_0001 || instr_compressed !== 1'b1) begin
            failures++;
            $display("FAIL odd_next: v=%b pc=%h instr=%h c=%b want 1/10a/00000001/1",
                     instr_valid, instr_pc, instr, instr_compressed);
        end
    endtask

    task automatic test_backpressure();
        int k;
        instr_ready = 1'b0;
        do_redirect(32'h0);
        for (int c = 0; c < 10; c++) begin
            if (instr_valid === 1'b1) begin
                checks++;
                if (instr_pc !== 32'h0 || instr !== addi_word(0)) begin
                    failures++;
                    $display("FAIL bp_stable[%0d]: pc=%h instr=%h want 0/%h", c, instr_pc, instr, addi_word(0));
                end
            end
            tick();
        end
        checks++;
        if (dut.q_count !== 3'd6 || ICACHE_ren !== 1'b0 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: count=%0d ren=%b v=%b want 6/0/1", dut.q_count, ICACHE_ren, instr_valid);
        end
        instr_ready = 1'b1;
        #1;
        k = 0;
        for (int c = 0; c < 20 && k < 6; c++) begin
            if (instr_valid === 1'b1) begin
                checks++;
                if (instr_pc !== 32'(4 * k) || instr !== addi_word(k)) begin
                    failures++;
                    $display("FAIL bp_release[%0d]: pc=%h instr=%h want %h/%h", k, instr_pc, instr, 4 * k, addi_word(k));
                end
                k++;
            end
            tick();
        end
        checks++;
        if (k != 6) begin
            failures++;
            $display("FAIL bp_timeout: got %0d instrs want 6", k);
        end
    endtask

    task automatic test_stall();
        ICACHE_stall = 1'b1;
        do_redirect(32'h0);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: ren=%b addr=%h v=%b want 1/0/0", s, ICACHE_ren, ICACHE_addr, instr_valid);
            end
            tick();
        end
        ICACHE_stall = 1'b0;
        #1;
        checks++;
        if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h0 || dut.q_count !== 3'd0) begin
            failures++;
            $display("FAIL stall_release: ren=%b addr=%h count=%0d want 1/0/0", ICACHE_ren, ICACHE_addr, dut.q_count);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== addi_word(0) || ICACHE_addr !== 30'h1) begin
            failures++;
            $display("FAIL stall_accept: v=%b pc=%h instr=%h addr=%h want 1/0/%h/1",
                     instr_valid, instr_pc, instr, ICACHE_addr, addi_word(0));
        end
    endtask

    task automatic test_redirect_collision();
        do_redirect(32'h0);
        tick();
        checks++;
        if (instr_valid !== 1'b1 || ICACHE_ren !== 1'b1) begin
            failures++;
            $display("FAIL coll_setup: v=%b ren=%b want 1/1", instr_valid, ICACHE_ren);
        end
        do_redirect(32'h40);
        checks++;
        if (dut.q_count !== 3'd0 || instr_pc !== 32'h40 || instr_valid !== 1'b0 ||
            ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h10) begin
            failures++;
            $display("FAIL coll_flush: count=%0d pc=%h v=%b ren=%b addr=%h want 0/40/0/1/10",
                     dut.q_count, instr_pc, instr_valid, ICACHE_ren, ICACHE_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h0000_4085) begin
            failures++;
            $display("FAIL coll_restart: v=%b pc=%h instr=%h want 1/40/00004085", instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_reset_mid();
        ICACHE_stall = 1'b1;
        do_redirect(32'h40);
        checks++;
        if (ICACHE_ren !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pending: ren=%b want 1", ICACHE_ren);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ICACHE_stall = 1'b0;
        #1;
        checks++;
        if (ICACHE_ren !== 1'b0 || instr_valid !== 1'b0 || dut.q_count !== 3'd0 ||
            instr_pc !== 32'h0 || ICACHE_addr !== 30'h0) begin
            failures++;
            $display("FAIL rmid_state: ren=%b v=%b count=%0d pc=%h addr=%h want 0/0/0/0/0",
                     ICACHE_ren, instr_valid, dut.q_count, instr_pc, ICACHE_addr);
        end
        tick();
        checks++;
        if (ICACHE_ren !== 1'b1 || ICACHE_addr !== 30'h0) begin
            failures++;
            $display("FAIL rmid_restart: ren=%b addr=%h want 1/0", ICACHE_ren, ICACHE_addr);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        ICACHE_stall   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
        end
        for (int i = 0; i < 8; i++) begin
            mem[i] = addi_word(i);
        end
        mem[8'h10] = 32'hA103_4085;
        mem[8'h11] = 32'h0085_0000;
        mem[8'h41] = 32'h0293_0001;
        mem[8'h42] = 32'h0001_0050;

        test_reset();
        test_sequential();
        test_mixed();
        test_redirect_odd();
        test_backpressure();
        test_stall();
        test_redirect_collision();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
